// File: rtl/hi_lo_mult_div.sv
// rtl/hi_lo_mult_div.sv - iterative HI/LO multiply/divide unit
//
// Purpose: owns the HI and LO registers. MULT/MULTU/DIV/DIVU are computed over
// WIDTH+1 busy cycles (WIDTH shift steps plus one sign-fixup cycle). MTHI/MTLO
// write in a single cycle. Requests that arrive while busy are dropped.
//
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous, active-high
//   start     request strobe, sampled on the rising edge
//   op        0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   rs_value  multiplicand / dividend / MTHI-MTLO source
//   rt_value  multiplier / divisor
//   hi        HI register (product high half / remainder)
//   lo        LO register (product low half / quotient)
//   busy      operation in flight
//   done      one-cycle pulse when hi/lo were just updated by mult/div
module hi_lo_mult_div #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_value,
  input  logic [WIDTH-1:0] rt_value,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // a_q: accumulator high half (mult) or partial remainder (div)
  // b_q: multiplier shifting out / dividend shifting out, quotient shifting in
  // m_q: multiplicand or divisor magnitude
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             div0_q, div0_d;
  logic             done_q, done_d;

  // Operand magnitudes; only MULT and DIV treat operands as signed.
  logic             signed_op;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign rs_neg    = signed_op & rs_value[WIDTH-1];
  assign rt_neg    = signed_op & rt_value[WIDTH-1];
  assign rs_mag    = rs_neg ? -rs_value : rs_value;
  assign rt_mag    = rt_neg ? -rt_value : rt_value;

  // Multiply step: conditional add into the high half, then shift the whole
  // {carry, a, b} right by one. The carry lands in the top of a.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, a_q} + (b_q[0] ? {1'b0, m_q} : '0);

  // Restoring divide step: shift the next dividend bit into the remainder and
  // keep the difference only if it did not go negative.
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  logic           div_ge;
  assign div_shift = {a_q, b_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, m_q};
  assign div_diff  = div_shift - {1'b0, m_q};

  // Sign fixup applied in the FIX cycle.
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_raw = {a_q, b_q};
  assign prod_fix = neg_q ? -prod_raw : prod_raw;
  assign quo_fix  = neg_q ? -b_q : b_q;
  assign rem_fix  = rem_neg_q ? -a_q : a_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      m_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      m_q       <= m_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    m_d       = m_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op <= 3'd3) begin
            a_d       = '0;
            b_d       = rs_mag;
            m_d       = rt_mag;
            is_div_d  = op[1];
            neg_d     = rs_neg ^ rt_neg;
            rem_neg_d = rs_neg;
            div0_d    = (rt_value == '0);
            cnt_d     = CNT_INIT;
            state_d   = S_CALC;
          end else if (op == OP_MTHI) begin
            hi_d = rs_value;
          end else if (op == OP_MTLO) begin
            lo_d = rs_value;
          end
        end
      end

      S_CALC: begin
        if (is_div_q) begin
          a_d = WIDTH'(div_ge ? div_diff : div_shift);
          b_d = {b_q[WIDTH-2:0], div_ge};
        end else begin
          a_d = mul_sum[WIDTH:1];
          b_d = {mul_sum[0], b_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          // Divide by zero: the restoring loop leaves the dividend magnitude
          // as remainder, and the remainder fixup restores rs exactly; only
          // the quotient needs forcing.
          lo_d = div0_q ? '1 : quo_fix;
          hi_d = rem_fix;
        end else begin
          lo_d = prod_fix[WIDTH-1:0];
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_hi_lo_mult_div.sv
// tb/tb_hi_lo_mult_div.sv - directed self-checking bench for hi_lo_mult_div
module tb_hi_lo_mult_div;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] rs_value;
  logic [W-1:0] rt_value;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  hi_lo_mult_div #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs_value (rs_value),
    .rt_value (rt_value),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present a one-cycle request; returns at the falling edge of cycle 1
  // (the request was sampled on the rising edge in between, edge 0).
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    start = 1'b1; op = o; rs_value = a; rt_value = b;
    @(negedge clock);
    start = 1'b0; op = 3'd6;
  endtask

  // Advance falling edges until done is seen or the budget runs out.
  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (done !== 1'b1 && c < 200) begin
      @(negedge clock);
      c++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = 3'd6; rs_value = '0; rt_value = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_mthi_mtlo;
    issue(3'd4, 32'h0000_1234, 32'h0);
    checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL mthi_hi got=%h exp=%h", hi, 32'h1234); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mthi_lo_kept got=%h exp=%h", lo, 32'h0); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_flags got=%b%b exp=00", busy, done); end
    issue(3'd5, 32'h0000_0055, 32'h0);
    checks++; if (lo !== 32'h0000_0055) begin errors++; $display("FAIL mtlo_lo got=%h exp=%h", lo, 32'h55); end
    checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL mtlo_hi_kept got=%h exp=%h", hi, 32'h1234); end
    issue(3'd7, 32'hDEAD_BEEF, 32'h0);
    checks++; if (hi !== 32'h0000_1234 || lo !== 32'h0000_0055) begin errors++; $display("FAIL noop got=%h/%h exp=%h/%h", hi, lo, 32'h1234, 32'h55); end
  endtask

  task automatic test_mult_latency;
    int bad;
    bad = 0;
    issue(3'd0, 32'd7, 32'd6);
    for (int c = 1; c <= 33; c++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      if (c == 20) begin
        checks++;
        if (hi !== 32'h0000_1234 || lo !== 32'h0000_0055) begin
          errors++; $display("FAIL mult_hold got=%h/%h exp=%h/%h", hi, lo, 32'h1234, 32'h55);
        end
      end
      @(negedge clock);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mult_busy_window bad_cycles=%0d exp=0", bad); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mult_done_c34 got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_c34 got=%b exp=0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL mult_7x6_hi got=%h exp=%h", hi, 32'h0); end
    checks++; if (lo !== 32'h0000_002A) begin errors++; $display("FAIL mult_7x6_lo got=%h exp=%h", lo, 32'h2A); end
    @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_mult_signs;
    int c;
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    wait_done(1, c);
    checks++; if (c != 34) begin errors++; $display("FAIL smult_latency got=%0d exp=34", c); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL smult_m3x5 got=%h/%h exp=ffffffff/fffffff1", hi, lo); end
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, c);
    checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_max got=%h/%h exp=fffffffe/00000001", hi, lo); end
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, c);
    checks++; if (hi !== 32'h0 || lo !== 32'h0000_0001) begin errors++; $display("FAIL smult_m1xm1 got=%h/%h exp=00000000/00000001", hi, lo); end
  endtask

  task automatic test_div;
    int c;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, c);
    checks++; if (c != 34) begin errors++; $display("FAIL div_latency got=%0d exp=34", c); end
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_m7_2 got=%h/%h exp=ffffffff/fffffffd", hi, lo); end
    issue(3'd3, 32'd100, 32'd7);
    wait_done(1, c);
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL divu_100_7 got=%h/%h exp=00000002/0000000e", hi, lo); end
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, c);
    checks++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin errors++; $display("FAIL div_overflow got=%h/%h exp=00000000/80000000", hi, lo); end
    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_done(1, c);
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin errors++; $display("FAIL div_7_m2 got=%h/%h exp=00000001/fffffffd", hi, lo); end
  endtask

  task automatic test_div_zero;
    int c;
    issue(3'd3, 32'd7, 32'd0);
    wait_done(1, c);
    checks++; if (c != 34) begin errors++; $display("FAIL divu0_latency got=%0d exp=34", c); end
    checks++; if (hi !== 32'd7 || lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_result got=%h/%h exp=00000007/ffffffff", hi, lo); end
    @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL divu0_done_once got=%b exp=0", done); end
    issue(3'd2, 32'hFFFF_FFF0, 32'd0);
    wait_done(1, c);
    checks++; if (hi !== 32'hFFFF_FFF0 || lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_signed got=%h/%h exp=fffffff0/ffffffff", hi, lo); end
  endtask

  task automatic test_ignore_while_busy;
    int c;
    issue(3'd0, 32'd3, 32'd4);
    repeat (9) @(negedge clock);
    start = 1'b1; op = 3'd5; rs_value = 32'h55;
    @(negedge clock);
    start = 1'b0; op = 3'd6;
    wait_done(11, c);
    checks++; if (c != 34) begin errors++; $display("FAIL ignore_latency got=%0d exp=34", c); end
    checks++; if (lo !== 32'd12 || hi !== 32'h0) begin errors++; $display("FAIL ignore_mtlo got=%h/%h exp=00000000/0000000c", hi, lo); end
  endtask

  task automatic test_reset_mid_op;
    int seen;
    seen = 0;
    issue(3'd4, 32'h0000_ABCD, 32'h0);
    issue(3'd2, 32'd1000, 32'd3);
    repeat (14) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midreset_hilo got=%h/%h exp=0/0", hi, lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    @(negedge clock);
    reset = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midreset_no_done activity_cycles=%0d exp=0", seen); end
  endtask

  task automatic test_back_to_back;
    int c;
    issue(3'd0, 32'd7, 32'd6);
    wait_done(1, c);
    start = 1'b1; op = 3'd0; rs_value = 32'd9; rt_value = 32'd9;
    @(negedge clock);
    start = 1'b0; op = 3'd6;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept got=%b%b exp=10", busy, done); end
    wait_done(1, c);
    checks++; if (c != 34) begin errors++; $display("FAIL b2b_latency got=%0d exp=34", c); end
    checks++; if (hi !== 32'h0 || lo !== 32'd81) begin errors++; $display("FAIL b2b_result got=%h/%h exp=00000000/00000051", hi, lo); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd6; rs_value = '0; rt_value = '0;
    test_reset;
    test_mthi_mtlo;
    test_mult_latency;
    test_mult_signs;
    test_div;
    test_div_zero;
    test_ignore_while_busy;
    test_reset_mid_op;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
